// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks every row of a 3- or 4-variable truth table, driving the row index
//   onto {w,x,y,z} and sampling the external function result f_in. It builds a
//   minterm mask and count, then streams the index of every true row
//   (ascending) over a valid/ready interface and pulses done.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start, nvars      : scan request (IDLE only); nvars 0 = 8 rows, 1 = 16 rows
//   w, x, y, z        : registered test vector, {w,x,y,z} = row index
//   f_in              : function result for the current vector
//   busy              : high whenever the FSM is not IDLE
//   mask, count       : minterm mask (bit i = f(i)) and number of minterms
//   m_valid, m_index,
//   m_ready           : minterm index stream
//   done              : one-cycle completion pulse
//   dbg_state         : current FSM state (IDLE=0, SCAN=1, EMIT=2, DONE=3)
//
// Stream handshake: a transfer happens on a rising edge where m_valid and
// m_ready are both 1. Once m_valid rises it stays high with m_index unchanged
// until that transfer; m_valid never depends on m_ready.
module truth_table_scanner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        nvars,
  input  logic        f_in,
  input  logic        m_ready,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic [15:0] mask,
  output logic [4:0]  count,
  output logic        m_valid,
  output logic [3:0]  m_index,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  r_state;
  logic        r_nvars;
  logic [3:0]  r_idx;    // row currently on {w,x,y,z}
  logic [3:0]  r_ptr;    // EMIT scan position over the mask
  logic [15:0] r_mask;
  logic [4:0]  r_count;

  logic [3:0]  w_last;
  logic        w_ptr_hit;
  logic        w_advance;

  assign w_last    = r_nvars ? 4'hF : 4'h7;
  assign w_ptr_hit = r_mask[r_ptr];
  // Empty positions are skipped one per cycle; set positions wait for a
  // completed handshake.
  assign w_advance = !w_ptr_hit || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_nvars <= 1'b0;
      r_idx   <= 4'd0;
      r_ptr   <= 4'd0;
      r_mask  <= 16'd0;
      r_count <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_nvars <= nvars;
            r_mask  <= 16'd0;
            r_count <= 5'd0;
            r_idx   <= 4'd0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_mask[r_idx] <= f_in;
          r_count       <= r_count + {4'd0, f_in};
          if (r_idx == w_last) begin
            // r_idx is left at the last row so the vector holds through
            // EMIT and DONE.
            r_ptr   <= 4'd0;
            r_state <= EMIT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        EMIT: begin
          if (w_advance) begin
            if (r_ptr == w_last) begin
              r_state <= DONE;
            end else begin
              r_ptr <= r_ptr + 4'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // In 3-variable mode r_idx never exceeds 7, so w stays 0 and mask[15:8]
  // is never written.
  assign w         = r_idx[3];
  assign x         = r_idx[2];
  assign y         = r_idx[1];
  assign z         = r_idx[0];
  assign busy      = (r_state != IDLE);
  assign mask      = r_mask;
  assign count     = r_count;
  assign m_valid   = (r_state == EMIT) && w_ptr_hit;
  assign m_index   = m_valid ? r_ptr : 4'd0;
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        nvars = 1'b0;
  logic        m_ready = 1'b1;
  logic        f_in;
  logic        w, x, y, z, busy, m_valid, done;
  logic [15:0] mask;
  logic [4:0]  count;
  logic [3:0]  m_index;
  logic [1:0]  dbg_state;

  // External function under test: a plain lookup table on the vector.
  logic [15:0] func = 16'd0;
  assign f_in = func[{w, x, y, z}];

  truth_table_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nvars(nvars), .f_in(f_in),
    .m_ready(m_ready), .w(w), .x(x), .y(y), .z(z), .busy(busy),
    .mask(mask), .count(count), .m_valid(m_valid), .m_index(m_index),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0]  exp_q[$];
  logic [15:0] exp_mask = 16'd0;
  int          exp_count = 0;
  int          exp_scan_len = 0;
  int          exp_emit_len = -1;
  bit          expect_done = 1'b0;
  bit          chk_reset = 1'b0;
  bit          to_flag = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         scan_cnt = 0;
  int         emit_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [3:0] prev_idx = 4'd0;
  logic [3:0] popped;

  always @(negedge clk) begin
    if (chk_reset) begin
      chk("rst_w", w, 0); chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_z", z, 0);
      chk("rst_busy", busy, 0); chk("rst_mask", mask, 0); chk("rst_count", count, 0);
      chk("rst_m_valid", m_valid, 0); chk("rst_m_index", m_index, 0); chk("rst_done", done, 0);
    end
    if (to_flag) chk("done_timeout", 1, 0);
    if (!rst_n) begin
      scan_cnt   = 0;
      emit_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_index", m_index, prev_idx);
      end
      prev_stall = m_valid && !m_ready;
      prev_idx   = m_index;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_index", m_index, 32'hFFFF_FFFF);
        end else begin
          popped = exp_q.pop_front();
          chk("m_index", m_index, popped);
        end
      end
      if (dbg_state == 2'd1) begin
        chk("scan_vector", {w, x, y, z}, scan_cnt);
        scan_cnt++;
      end
      if (dbg_state == 2'd2) emit_cnt++;
      if (dbg_state != 2'd2 && m_valid) chk("m_valid_outside_emit", m_valid, 0);
      if (done) begin
        chk("done_expected", 1, expect_done);
        chk("mask", mask, exp_mask);
        chk("count", count, exp_count);
        chk("scan_len", scan_cnt, exp_scan_len);
        chk("stream_drained", exp_q.size(), 0);
        if (exp_emit_len >= 0) chk("emit_len", emit_cnt, exp_emit_len);
      end
      if (dbg_state == 2'd0) begin
        scan_cnt = 0;
        emit_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic flag_timeout();
    to_flag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 to_flag = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_scan(input logic nv, input logic [15:0] fn, input logic [15:0] emask,
                          input int ecount, input int emit_len, input bit stall, input bit poke);
    bit seen;
    func         = fn;
    nvars        = nv;
    exp_mask     = emask;
    exp_count    = ecount;
    exp_scan_len = nv ? 16 : 8;
    exp_emit_len = emit_len;
    expect_done  = 1'b1;
    for (int i = 0; i < 16; i++) if (emask[i]) exp_q.push_back(4'(i));
    m_ready = !stall;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (poke) begin
      // A start request in the middle of SCAN must be ignored.
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    if (stall) begin
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        if (m_valid) seen = 1'b1;
      end
      if (!seen) flag_timeout();
      repeat (3) @(posedge clk);
      #1 m_ready = 1'b1;
    end
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) flag_timeout();
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_scan();
    bit seen;
    func         = 16'h88CE;
    nvars        = 1'b1;
    expect_done  = 1'b0;
    m_ready      = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (dbg_state == 2'd1 && {w, x, y, z} == 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) flag_timeout();
    #1 rst_n = 1'b0;
    chk_reset = 1'b1;
    @(negedge clk);
    #1 chk_reset = 1'b0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    chk_reset = 1'b1;
    @(negedge clk);
    #1 chk_reset = 1'b0;
    rst_n = 1'b1;

    // 3-var, minterms {1,5,6,7}
    run_scan(1'b0, 16'h00E2, 16'h00E2, 4, -1, 1'b0, 1'b0);
    // 4-var, minterms {1,2,3,6,7,11,15}, with a stray start mid-scan
    run_scan(1'b1, 16'h88CE, 16'h88CE, 7, -1, 1'b0, 1'b1);
    // 3-var constant 0: eight silent EMIT cycles
    run_scan(1'b0, 16'h0000, 16'h0000, 0, 8, 1'b0, 1'b0);
    // 3-var whose table has only upper-half ones: rows 8..15 are never visited
    run_scan(1'b0, 16'hFF00, 16'h0000, 0, 8, 1'b0, 1'b0);
    // 4-var constant 1 with a 3-cycle stall at index 0
    run_scan(1'b1, 16'hFFFF, 16'hFFFF, 16, -1, 1'b1, 1'b0);
    // reset at SCAN row 5, then a fresh full run
    abort_scan();
    run_scan(1'b1, 16'h88CE, 16'h88CE, 7, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: request a scan; honoured only in IDLE.
REQ-005 Port nvars, input, 1 bit: 0 = 3-variable function (8 rows); 1 = 4-variable function (16 rows); sampled with start.
REQ-006 Port w, x, y, z, outputs, 1 bit each, registered: test vector driven to the external function under test; {w,x,y,z} = row index.
REQ-007 Port f_in, input, 1 bit: output of the function under test for the current vector.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port mask, output, 16 bits: minterm mask; bit i = f(i); stable from entry to EMIT until the next accepted start.
REQ-010 Port count, output, 5 bits: number of minterms (0..16).
REQ-011 Ports m_valid (output, 1 bit), m_index (output, 4 bits), m_ready (input, 1 bit): valid/ready stream of minterm indices.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, EMIT and DONE.
- IDLE->SCAN on start=1: latch nvars; clear mask, count and row index; vector = 0.
- SCAN->EMIT after the last row is sampled.
- EMIT->DONE after the last pointer position.
- DONE->IDLE unconditionally after one cycle.
REQ-014 In SCAN, each row index SHALL be presented on w,x,y,z for exactly one cycle; f_in SHALL be captured into mask[index] at the closing edge of that cycle, count incremented by f_in, and index incremented.
REQ-015 The last row SHALL be 7 for nvars=0 and 15 for nvars=1; SCAN SHALL last exactly 8 or 16 cycles.
REQ-016 For nvars=0, w SHALL be held at 0, {x,y,z} = index[2:0], and mask[15:8] SHALL remain 0.
REQ-017 On entry to EMIT, the pointer SHALL be set to 0; w,x,y,z SHALL hold their last SCAN values through EMIT and DONE.
REQ-018 In EMIT, if mask[pointer]=0, then m_valid=0 and the pointer SHALL advance one position per cycle.
REQ-019 In EMIT, if mask[pointer]=1, then m_valid=1 and m_index=pointer; the pointer SHALL advance only on a cycle with m_valid=1 and m_ready=1.
REQ-020 While m_valid=1 and m_ready=0, m_valid and m_index SHALL remain stable.
REQ-021 Indices SHALL be emitted in strictly ascending order, each exactly once.
REQ-022 EMIT->DONE SHALL occur when the pointer is at the last row and either mask[pointer]=0 or the handshake completes.
REQ-023 done SHALL be high only during the single DONE cycle; m_valid SHALL be 0 outside EMIT.
REQ-024 start SHALL be ignored in SCAN, EMIT and DONE; start asserted together with done SHALL NOT be accepted until IDLE.
REQ-025 A constant-0 function SHALL pass through EMIT without ever asserting m_valid and still produce done.
REQ-026 count SHALL reach 16 without overflow for a constant-1 4-variable function.

Reset
REQ-027 On rst_n=0, at any time, the block SHALL immediately force IDLE and set w,x,y,z, busy, mask, count, m_valid, m_index and done to 0.
REQ-028 Reset mid-SCAN or mid-EMIT SHALL abandon the operation with no done pulse.
REQ-029 After rst_n is released, the block SHALL accept start on the first rising edge.

Verification
REQ-030 3-variable, f = minterms {1,5,6,7}, m_ready=1 -> mask=0x00E2, count=4, m_index stream 1,5,6,7, one done pulse.
REQ-031 4-variable, f = minterms {1,2,3,6,7,11,15}, m_ready=1 -> mask=0x88CE, count=7, stream 1,2,3,6,7,11,15.
REQ-032 3-variable, constant 0 -> 8 SCAN cycles, then 8 EMIT cycles with m_valid=0, then done=1; mask=0, count=0.
REQ-033 4-variable, constant 1, m_ready held 0 for 3 cycles at index 0 -> m_index=0 held stable; stream 0..15 follows; count=16.
REQ-034 rst_n pulsed low during SCAN row 5 -> all outputs 0 at once, no done; a fresh start yields a correct full result.
